pot_scan_ctrl: RTL and testbench
================================

Name: pot_scan_ctrl

Overview:
Scheduler for the single shared A2D path (A2D_intf → ADC128S over SPI). It round-robins the five band-gain slide pots and the volume pot and holds the latest 12-bit reading of each for the equalizer gain stages. It also arbitrates an auxiliary requester for one-off conversions on any channel. It sits between the A2D interface and the band-scaling/volume logic in the Equalizer top level.

Parameters:
SCAN_GAP, 1024, idle clocks between end of one conversion and start of the next scan conversion (≥1)
AUX_EVERY, 1, max scan conversions between two aux grants when aux is pending (≥1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
strt_cnv  out  1  one-cycle pulse to A2D_intf: start conversion
chnnl  out  3  channel for the conversion; stable from strt_cnv until cnv_cmplt
cnv_cmplt  in  1  one-cycle pulse from A2D_intf: res valid
res  in  12  conversion result
aux_req  in  1  aux requester wants a conversion; level, held until aux_done
aux_chnnl  in  3  aux channel; sampled on grant
aux_done  out  1  one-cycle pulse: aux_res valid
aux_res  out  12  aux result; held until next aux_done
POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, VOLUME  out  12 each  latest pot readings
all_vld  out  1  high once every pot has been read at least once since reset

Behaviour:
- Reset: all outputs 0; scan index 0; gap timer 0; state IDLE.
- Scan order and channel map (fixed): B1=ch0, LP=ch1, B3=ch2, HP=ch3, B2=ch4, VOLUME=ch7; index 0..5 wraps 5→0.
- States: IDLE, SCAN_WAIT, AUX_WAIT.
- IDLE: gap timer counts up; when timer == SCAN_GAP-1 (or aux pending, see arbitration), issue strt_cnv and drive chnnl. The first conversion after reset starts SCAN_GAP cycles after reset release.
- Arbitration at each start decision: aux wins if aux_req=1 and scans_since_aux ≥ AUX_EVERY; otherwise scan. An aux grant does not wait for the gap timer; scans do. scans_since_aux saturates at AUX_EVERY and clears on aux grant.
- SCAN_WAIT: on cnv_cmplt, load res into the indexed pot register the same edge (visible the next cycle); advance index; clear gap timer; → IDLE. all_vld sets when index 5 completes and stays set.
- AUX_WAIT: on cnv_cmplt, aux_res←res, aux_done=1 for one cycle; pot registers untouched; scan index unchanged; clear gap timer; → IDLE.
- aux_chnnl is captured at grant; later changes are ignored.
- cnv_cmplt in IDLE is ignored; no timeout in WAIT states.
- strt_cnv never reasserts before cnv_cmplt (one outstanding conversion).
- Reset mid-conversion returns all state to reset values; a late cnv_cmplt after reset arrives in IDLE and is ignored.
- aux_req deasserted before grant: request withdrawn, no aux_done.

Optional Feature:
POT_FILT_EN: when defined, scan results are smoothed: reg ← reg + ((res − reg) >>> 2), using a 13-bit signed difference and an arithmetic shift; the first load after reset is direct (filter seeded). Undefined: reg ← res directly. aux_res is never filtered.

Decomposition:
- Shared package eq_pkg: channel constants (CH_B1=0, CH_LP=1, CH_B3=2, CH_HP=3, CH_B2=4, CH_VOL=7), scan-order array, state enum.
- Optional sub-module pot_filt (one 12-bit smoothing register), instantiated six times under POT_FILT_EN.

Test Plan:
- Reset release, SCAN_GAP=16; bench A2D model returns 0x100*ch+0x055 → chnnl sequence 0,1,2,3,4,7; POT_B1=0x055, LP=0x155, B3=0x255, HP=0x355, B2=0x455, VOLUME=0x755; all_vld rises after the VOLUME load; strt_cnv spacing = 16 clocks + conversion latency.
- aux_req with aux_chnnl=5 during a SCAN_WAIT → aux granted immediately after that completion, without waiting for the gap; aux_done with aux_res=0x555; the next scan resumes at the following index.
- aux_req held continuously, AUX_EVERY=2 → pattern scan, scan, aux, scan, scan, aux; scan sequence never skipped.
- rst_n asserted mid-SCAN_WAIT, then cnv_cmplt pulsed → all outputs 0, no register loaded, all_vld=0.
- POT_FILT_EN, channel 0 returns 0x000 then 0x400 repeatedly → POT_B1 = 0x000, 0x100, 0x1C0, 0x250, converging to 0x400.

Source files
------------

// File: rtl/eq_pkg.sv
// Shared equalizer constants: pot channel map, scan order and scan FSM states.
package eq_pkg;

    localparam logic [2:0] CH_B1  = 3'd0;
    localparam logic [2:0] CH_LP  = 3'd1;
    localparam logic [2:0] CH_B3  = 3'd2;
    localparam logic [2:0] CH_HP  = 3'd3;
    localparam logic [2:0] CH_B2  = 3'd4;
    localparam logic [2:0] CH_VOL = 3'd7;

    localparam int         N_POTS   = 6;
    localparam logic [2:0] IDX_LAST = 3'd5;

    localparam logic [N_POTS-1:0][2:0] SCAN_ORDER =
        {CH_VOL, CH_B2, CH_HP, CH_B3, CH_LP, CH_B1};

    typedef enum logic [1:0] {
        IDLE,
        SCAN_WAIT,
        AUX_WAIT
    } state_t;

    function automatic logic [2:0] scan_chnnl(input logic [2:0] idx);
        return (idx <= IDX_LAST) ? SCAN_ORDER[idx] : CH_B1;
    endfunction

    function automatic logic [2:0] next_idx(input logic [2:0] idx);
        return (idx >= IDX_LAST) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/pot_filt.sv
// One smoothing pot register: q <- q + ((d - q) >>> 2), seeded by the first load.
module pot_filt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld,
    input  logic [11:0] d,
    output logic [11:0] q
);

    logic               seeded;
    logic signed [12:0] diff;
    logic signed [12:0] step;

    assign diff = $signed({1'b0, d}) - $signed({1'b0, q});
    assign step = diff >>> 2;

    // Result always lies between q and d, so a 12-bit wrap-around add is exact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q      <= '0;
            seeded <= 1'b0;
        end else if (ld) begin
            seeded <= 1'b1;
            q      <= seeded ? q + step[11:0] : d;
        end
    end

endmodule

// File: rtl/pot_scan_ctrl.sv
// Round-robin pot scanner sharing the A2D path with an auxiliary requester.
// Define POT_FILT_EN to smooth scanned pot readings through pot_filt.
module pot_scan_ctrl
    import eq_pkg::*;
#(
    parameter int SCAN_GAP  = 1024,
    parameter int AUX_EVERY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    input  logic        aux_req,
    input  logic [2:0]  aux_chnnl,
    output logic        aux_done,
    output logic [11:0] aux_res,
    output logic [11:0] POT_LP,
    output logic [11:0] POT_B1,
    output logic [11:0] POT_B2,
    output logic [11:0] POT_B3,
    output logic [11:0] POT_HP,
    output logic [11:0] VOLUME,
    output logic        all_vld
);

    localparam int GW = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;
    localparam int SW = $clog2(AUX_EVERY + 1);

    localparam logic [GW-1:0] GAP_LAST = GW'(SCAN_GAP - 1);
    localparam logic [SW-1:0] AUX_MAX  = SW'(AUX_EVERY);

    state_t        state;
    state_t        state_n;
    logic [GW-1:0] gap;
    logic [SW-1:0] since;
    logic [2:0]    idx;
    logic [11:0]   pots [N_POTS];

    logic aux_win;
    logic grant_scan;
    logic grant_aux;
    logic scan_ld;
    logic aux_ld;

    assign aux_win = aux_req && (since >= AUX_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Aux requests bypass the gap timer; scans only start when it expires.
    always_comb begin
        state_n    = state;
        grant_scan = 1'b0;
        grant_aux  = 1'b0;
        scan_ld    = 1'b0;
        aux_ld     = 1'b0;
        unique case (state)
            IDLE: begin
                if (aux_win) begin
                    grant_aux = 1'b1;
                    state_n   = AUX_WAIT;
                end else if (gap == GAP_LAST) begin
                    grant_scan = 1'b1;
                    state_n    = SCAN_WAIT;
                end
            end
            SCAN_WAIT: begin
                if (cnv_cmplt) begin
                    scan_ld = 1'b1;
                    state_n = IDLE;
                end
            end
            AUX_WAIT: begin
                if (cnv_cmplt) begin
                    aux_ld  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strt_cnv <= 1'b0;
            chnnl    <= '0;
            aux_done <= 1'b0;
            aux_res  <= '0;
            all_vld  <= 1'b0;
            gap      <= '0;
            since    <= '0;
            idx      <= '0;
        end else begin
            strt_cnv <= grant_scan | grant_aux;
            aux_done <= aux_ld;
            if (grant_scan)     chnnl <= scan_chnnl(idx);
            else if (grant_aux) chnnl <= aux_chnnl;
            if (scan_ld || aux_ld)
                gap <= '0;
            else if (state == IDLE && !grant_scan && !grant_aux)
                gap <= gap + 1'b1;
            if (grant_aux)
                since <= '0;
            else if (grant_scan && since != AUX_MAX)
                since <= since + 1'b1;
            if (scan_ld) begin
                idx <= next_idx(idx);
                if (idx == IDX_LAST) all_vld <= 1'b1;
            end
            if (aux_ld) aux_res <= res;
        end
    end

`ifdef POT_FILT_EN
    for (genvar g = 0; g < N_POTS; g++) begin : g_filt
        pot_filt u_filt (
            .clk   (clk),
            .rst_n (rst_n),
            .ld    (scan_ld && idx == 3'(g)),
            .d     (res),
            .q     (pots[g])
        );
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_POTS; i++) pots[i] <= '0;
        end else if (scan_ld) begin
            pots[idx] <= res;
        end
    end
`endif

    assign POT_B1 = pots[0];
    assign POT_LP = pots[1];
    assign POT_B3 = pots[2];
    assign POT_HP = pots[3];
    assign POT_B2 = pots[4];
    assign VOLUME = pots[5];

endmodule

// File: tb/tb_pot_scan_ctrl.sv
// Directed bench for pot_scan_ctrl acting as the A2D interface itself.
module tb_pot_scan_ctrl;

    localparam int LAT = 3;
    localparam int NV  = 17;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt = 1'b0;
    logic [11:0] res = '0;
    logic        aux_req = 1'b0;
    logic [2:0]  aux_chnnl = '0;
    logic        aux_done;
    logic [11:0] aux_res;
    logic [11:0] POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, VOLUME;
    logic        all_vld;

    int checks = 0;
    int errors = 0;
    bit filt_mode = 1'b0;
    int b1_loads = 0;

    always #5 clk = ~clk;

    pot_scan_ctrl #(.SCAN_GAP(16), .AUX_EVERY(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .aux_req   (aux_req),
        .aux_chnnl (aux_chnnl),
        .aux_done  (aux_done),
        .aux_res   (aux_res),
        .POT_LP    (POT_LP),
        .POT_B1    (POT_B1),
        .POT_B2    (POT_B2),
        .POT_B3    (POT_B3),
        .POT_HP    (POT_HP),
        .VOLUME    (VOLUME),
        .all_vld   (all_vld)
    );

    // req_op: 0 none, 1 raise and hold, 2 raise then withdraw, 3 drop
    typedef struct {
        logic [1:0]  req_op;
        logic [2:0]  aux_ch;
        logic        is_aux;
        logic [2:0]  ch;
        int          gap;
        logic [11:0] val;
        logic        vld;
    } vec_t;

    vec_t vec [NV];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] pot_of(input logic [2:0] ch);
        case (ch)
            3'd0:    return POT_B1;
            3'd1:    return POT_LP;
            3'd2:    return POT_B3;
            3'd3:    return POT_HP;
            3'd4:    return POT_B2;
            3'd7:    return VOLUME;
            default: return 12'hFFF;
        endcase
    endfunction

    function automatic logic [11:0] a2d_val(input logic [2:0] ch);
        if (filt_mode && ch == 3'd0)
            return (b1_loads == 0) ? 12'h000 : 12'h400;
        return {1'b0, ch, 8'h55};
    endfunction

    task automatic wait_start(output int n);
        n = 0;
        while (strt_cnv !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic complete(input logic [2:0] ch);
        cnv_cmplt = 1'b1;
        res       = a2d_val(ch);
        if (ch == 3'd0) b1_loads++;
        @(negedge clk);
        cnv_cmplt = 1'b0;
        res       = '0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_strt"},  32'(strt_cnv), 0);
        chk({tag, "_chnnl"}, 32'(chnnl), 0);
        chk({tag, "_adone"}, 32'(aux_done), 0);
        chk({tag, "_ares"},  32'(aux_res), 0);
        chk({tag, "_pots"},  32'(POT_LP | POT_B1 | POT_B2 | POT_B3 | POT_HP | VOLUME), 0);
        chk({tag, "_vld"},   32'(all_vld), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        logic [2:0] ch;
        logic [11:0] filt_exp [4];

        vec[0]  = '{2'd0, 3'd0, 1'b0, 3'd0, 16, 12'h055, 1'b0};
        vec[1]  = '{2'd0, 3'd0, 1'b0, 3'd1, 16, 12'h155, 1'b0};
        vec[2]  = '{2'd0, 3'd0, 1'b0, 3'd2, 16, 12'h255, 1'b0};
        vec[3]  = '{2'd0, 3'd0, 1'b0, 3'd3, 16, 12'h355, 1'b0};
        vec[4]  = '{2'd0, 3'd0, 1'b0, 3'd4, 16, 12'h455, 1'b0};
        vec[5]  = '{2'd0, 3'd0, 1'b0, 3'd7, 16, 12'h755, 1'b1};
        vec[6]  = '{2'd1, 3'd5, 1'b0, 3'd0, 16, 12'h055, 1'b1};
        vec[7]  = '{2'd1, 3'd3, 1'b1, 3'd5, 1,  12'h555, 1'b1};
        vec[8]  = '{2'd0, 3'd0, 1'b0, 3'd1, 16, 12'h155, 1'b1};
        vec[9]  = '{2'd0, 3'd0, 1'b0, 3'd2, 16, 12'h255, 1'b1};
        vec[10] = '{2'd0, 3'd0, 1'b1, 3'd3, 1,  12'h355, 1'b1};
        vec[11] = '{2'd0, 3'd0, 1'b0, 3'd3, 16, 12'h355, 1'b1};
        vec[12] = '{2'd0, 3'd0, 1'b0, 3'd4, 16, 12'h455, 1'b1};
        vec[13] = '{2'd3, 3'd0, 1'b1, 3'd3, 1,  12'h355, 1'b1};
        vec[14] = '{2'd0, 3'd0, 1'b0, 3'd7, 16, 12'h755, 1'b1};
        vec[15] = '{2'd2, 3'd5, 1'b0, 3'd0, 16, 12'h055, 1'b1};
        vec[16] = '{2'd0, 3'd0, 1'b0, 3'd1, 16, 12'h155, 1'b1};

        filt_exp[0] = 12'h000;
        filt_exp[1] = 12'h100;
        filt_exp[2] = 12'h1C0;
        filt_exp[3] = 12'h250;

        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            wait_start(n);
            chk($sformatf("v%0d_gap", i), 32'(n), 32'(vec[i].gap));
            chk($sformatf("v%0d_chnnl", i), 32'(chnnl), 32'(vec[i].ch));
            ch = chnnl;
            case (vec[i].req_op)
                2'd1, 2'd2: begin
                    aux_req   = 1'b1;
                    aux_chnnl = vec[i].aux_ch;
                end
                2'd3:    aux_req = 1'b0;
                default: ;
            endcase
            @(negedge clk);
            chk($sformatf("v%0d_pulse", i), 32'(strt_cnv), 0);
            if (vec[i].req_op == 2'd2) aux_req = 1'b0;
            repeat (LAT - 1) @(negedge clk);
            chk($sformatf("v%0d_hold", i), 32'(chnnl), 32'(vec[i].ch));
            complete(ch);
            if (vec[i].is_aux) begin
                chk($sformatf("v%0d_adone", i), 32'(aux_done), 1);
                chk($sformatf("v%0d_ares", i), 32'(aux_res), 32'(vec[i].val));
            end else begin
                chk($sformatf("v%0d_adone", i), 32'(aux_done), 0);
                chk($sformatf("v%0d_pot", i), 32'(pot_of(vec[i].ch)), 32'(vec[i].val));
            end
            chk($sformatf("v%0d_vld", i), 32'(all_vld), 32'(vec[i].vld));
        end

        // Reset in the middle of a scan conversion, then a stray completion.
        wait_start(n);
        chk("mid_start", 32'(n < 200), 1);
        @(negedge clk);
        do_reset();
        check_zero("midrst");
        @(negedge clk);
        complete(3'd2);
        check_zero("late_cmplt");
        wait_start(n);
        chk("post_rst_gap", 32'(n), 14);
        chk("post_rst_ch", 32'(chnnl), 0);
        repeat (LAT) @(negedge clk);
        complete(3'd0);
        chk("post_rst_b1", 32'(POT_B1), 32'h055);
        chk("post_rst_vld", 32'(all_vld), 0);

`ifdef POT_FILT_EN
        do_reset();
        filt_mode = 1'b1;
        b1_loads  = 0;
        for (int k = 0; k < 19; k++) begin
            wait_start(n);
            chk($sformatf("f%0d_start", k), 32'(n < 200), 1);
            ch = chnnl;
            repeat (LAT) @(negedge clk);
            complete(ch);
            if (ch == 3'd0 && b1_loads >= 1 && b1_loads <= 4)
                chk($sformatf("filt_b1_%0d", b1_loads - 1),
                    32'(POT_B1), 32'(filt_exp[b1_loads - 1]));
        end
        chk("filt_loads", 32'(b1_loads), 4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
